multi_probe_detector: RTL and testbench
=======================================

// Module: multi_probe_detector
// PURPOSE
//   Multi-channel successor of the single-probe detector. Each sample: pulse trigger_data_out, wait a settle time,
//   sample NUM_CH synchronised probe inputs; per-channel hit counts accumulate over a programmable window.
//   Sits behind AXI2NATIVE (native register port) in the probe subsystem; single-shot or continuous windows.
// PARAMETERS
//   NUM_CH             4      probe channels (1..16)
//   CNT_WIDTH          16     hit-counter width, saturating
//   NATIVE_ADDR_WDITH  4      register address width; must cover 3+2*NUM_CH words
//   NATIVE_DATA_WIDTH  32     register data width (>= CNT_WIDTH)
//   AVER_DEFAULT       10000  reset value of window length (samples per window)
//   SETTLE_CYCLES      2      idle cycles between trigger pulse and sample (>=1)
// PORTS
//   S_AXI_aclk         in   1            single clock: native interface, FSM and synchronisers
//   S_AXI_aresetn      in   1            asynchronous, active-low reset
//   NATIVE_EN          in   1            access strobe, one cycle
//   NATIVE_WR          in   1            1 = write, 0 = read
//   NATIVE_ADDR        in   NATIVE_ADDR_WDITH   word address
//   NATIVE_DATA_IN     in   NATIVE_DATA_WIDTH   write data
//   NATIVE_DATA_OUT    out  NATIVE_DATA_WIDTH   read data, valid with NATIVE_READY
//   NATIVE_READY       out  1            access complete, one-cycle pulse
//   probe_signal_in    in   NUM_CH       asynchronous probe inputs
//   trigger_data_out   out  1            stimulus pulse, registered
//   done_irq           out  1            one-cycle pulse per completed window
// BEHAVIOUR
//   Reset: all outputs 0; FSM IDLE; AVER=AVER_DEFAULT; counts, latches, ctrl, sticky done = 0.
//   Sync: 2-FF chain per channel (ASYNC_REG), reset to 0; sample uses 2nd stage.
//   Registers: 0 CTRL W: b0 start (self-clearing), b1 continuous, b2 clear (self-clearing); R: {b1}.
//     1 STATUS R: b0 busy, b1 done (sticky; reading STATUS clears it). 2 AVER R/W, low 24 bits.
//     3..3+NUM_CH-1 latched hit count ch i, zero-extended. Unmapped read returns 0, write ignored.
//   Handshake: NATIVE_READY pulses exactly 1 cycle after each NATIVE_EN (read or write); read data registered same cycle.
//   FSM: IDLE -start-> LOAD (counts<=0, remaining<=max(AVER,1)) -> TRIG (trigger_data_out=1) -> SETTLE (SETTLE_CYCLES cycles)
//     -> SAMPLE (count[i]+=sync[i], remaining-=1) -> CHECK: remaining==0 ? DONE : TRIG.
//     DONE: latches<=counts, done<=1, done_irq=1; -> LOAD if continuous else IDLE.
//   Cost: 3+SETTLE_CYCLES cycles per sample, +2 (LOAD, DONE) per window; trigger period = 3+SETTLE_CYCLES.
//   Arithmetic: counters saturate at 2^CNT_WIDTH-1, never wrap. AVER=0 runs one sample.
//   Busy = FSM not IDLE. start while busy ignored. AVER write while busy ignored (STATUS unaffected).
//   Clearing continuous mid-window: current window completes, then IDLE.
//   clear: zeroes latches and sticky done; if DONE in same cycle, DONE's new latch/done values win.
//   STATUS read coinciding with DONE: done reads 0, sticky done then sets (event not lost).
//   Async reset mid-window: immediate return to reset state, no partial latch, no done_irq.
// CONFIGURATION
//   MULTI_PROBE_EDGE_EN defined: per-channel rising-edge counters (sync sample 0->1 between consecutive samples,
//     first sample after LOAD compares to 0), CNT_WIDTH saturating, latched at DONE, read at 3+NUM_CH+i.
//   Not defined: no edge logic; addresses 3+NUM_CH.. read 0.
// TESTING
//   T1 reset defaults: read AVER -> 10000, STATUS -> 0, all counts 0, trigger_data_out=0.
//   T2 AVER=8, probes 4'b0101 held, start -> 8 trigger pulses spaced 5 cycles, done_irq once; counts 8,0,8,0; STATUS b1=1 then 0 on re-read.
//   T3 CNT_WIDTH=4, AVER=20, probe[0]=1 -> count0 = 15 (saturated), not 4.
//   T4 continuous=1, AVER=3 -> done_irq every 3*5+2=17 cycles; clear continuous mid-window -> one more done_irq, then busy=0.
//   T5 start, deassert S_AXI_aresetn at sample 2 of 8 -> trigger 0 immediately, no done_irq, counts/latches 0, AVER=10000.
//   T6 MULTI_PROBE_EDGE_EN: probe[1] toggles every sample, AVER=8 -> edge count1 = 4, hit count1 = 4.

Source files
------------

// File: rtl/multi_probe_detector.sv
// Multi-channel probe detector: each sample pulses the trigger, waits, then counts hits on NUM_CH synchronised probes.
// Defining MULTI_PROBE_EDGE_EN adds per-channel rising-edge counters read at 3+NUM_CH+i.
module multi_probe_detector #(
    parameter int NUM_CH            = 4,
    parameter int CNT_WIDTH         = 16,
    parameter int NATIVE_ADDR_WDITH = 4,
    parameter int NATIVE_DATA_WIDTH = 32,
    parameter int AVER_DEFAULT      = 10000,
    parameter int SETTLE_CYCLES     = 2
) (
    input  logic                         S_AXI_aclk,
    input  logic                         S_AXI_aresetn,
    input  logic                         NATIVE_EN,
    input  logic                         NATIVE_WR,
    input  logic [NATIVE_ADDR_WDITH-1:0] NATIVE_ADDR,
    input  logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_IN,
    output logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_OUT,
    output logic                         NATIVE_READY,
    input  logic [NUM_CH-1:0]            probe_signal_in,
    output logic                         trigger_data_out,
    output logic                         done_irq
);

    localparam int AW = 24;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [NATIVE_ADDR_WDITH-1:0] ADDR_CTRL   = NATIVE_ADDR_WDITH'(0);
    localparam logic [NATIVE_ADDR_WDITH-1:0] ADDR_STATUS = NATIVE_ADDR_WDITH'(1);
    localparam logic [NATIVE_ADDR_WDITH-1:0] ADDR_AVER   = NATIVE_ADDR_WDITH'(2);

    // IDLE -> LOAD -> TRIG -> SETTLE -> SAMPLE -> CHECK -> (TRIG | DONE) -> (LOAD | IDLE)
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TRIG, S_SETTLE, S_SAMPLE, S_CHECK, S_DONE
    } state_t;

    state_t                         r_state, w_next;
    logic [AW-1:0]                  r_aver, r_remaining;
    logic [SW-1:0]                  r_settle;
    logic                           r_cont, r_done, r_trig, r_irq, r_ready;
    logic [NATIVE_DATA_WIDTH-1:0]   r_rdata, w_rdata;
    (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] r_sync1;
    (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] r_sync2;
    logic [CNT_WIDTH-1:0]           r_cnt   [NUM_CH];
    logic [CNT_WIDTH-1:0]           r_latch [NUM_CH];
`ifdef MULTI_PROBE_EDGE_EN
    logic [NUM_CH-1:0]              r_prev;
    logic [CNT_WIDTH-1:0]           r_edge       [NUM_CH];
    logic [CNT_WIDTH-1:0]           r_edge_latch [NUM_CH];
`endif
    logic w_wr, w_rd, w_start, w_clear, w_status_rd, w_aver_wr, w_busy, w_unused_data;

    assign w_wr          = NATIVE_EN & NATIVE_WR;
    assign w_rd          = NATIVE_EN & ~NATIVE_WR;
    assign w_busy        = (r_state != S_IDLE);
    assign w_start       = w_wr && (NATIVE_ADDR == ADDR_CTRL) && NATIVE_DATA_IN[0];
    assign w_clear       = w_wr && (NATIVE_ADDR == ADDR_CTRL) && NATIVE_DATA_IN[2];
    assign w_status_rd   = w_rd && (NATIVE_ADDR == ADDR_STATUS);
    assign w_aver_wr     = w_wr && (NATIVE_ADDR == ADDR_AVER) && !w_busy;
    assign w_unused_data = ^NATIVE_DATA_IN;

    assign NATIVE_DATA_OUT  = r_rdata;
    assign NATIVE_READY     = r_ready;
    assign trigger_data_out = r_trig;
    assign done_irq         = r_irq;

    always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= probe_signal_in;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_LOAD;
            S_LOAD:   w_next = S_TRIG;
            S_TRIG:   w_next = S_SETTLE;
            S_SETTLE: if (r_settle == '0) w_next = S_SAMPLE;
            S_SAMPLE: w_next = S_CHECK;
            S_CHECK:  w_next = (r_remaining == '0) ? S_DONE : S_TRIG;
            S_DONE:   w_next = r_cont ? S_LOAD : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            r_state     <= S_IDLE;
            r_settle    <= '0;
            r_remaining <= '0;
            r_trig      <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_trig  <= (w_next == S_TRIG);
            r_irq   <= (w_next == S_DONE);
            if (r_state == S_TRIG)
                r_settle <= SW'(SETTLE_CYCLES - 1);
            else if (r_state == S_SETTLE && r_settle != '0)
                r_settle <= r_settle - 1'b1;
            // AVER of zero still runs a single sample
            if (r_state == S_LOAD)
                r_remaining <= (r_aver == '0) ? AW'(1) : r_aver;
            else if (r_state == S_SAMPLE)
                r_remaining <= r_remaining - 1'b1;
        end
    end

    always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else if (r_state == S_LOAD) begin
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else if (r_state == S_SAMPLE) begin
            for (int i = 0; i < NUM_CH; i++)
                if (r_sync2[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
        end
    end

`ifdef MULTI_PROBE_EDGE_EN
    always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            r_prev <= '0;
            for (int i = 0; i < NUM_CH; i++) r_edge[i] <= '0;
        end else if (r_state == S_LOAD) begin
            r_prev <= '0;
            for (int i = 0; i < NUM_CH; i++) r_edge[i] <= '0;
        end else if (r_state == S_SAMPLE) begin
            r_prev <= r_sync2;
            for (int i = 0; i < NUM_CH; i++)
                if (r_sync2[i] && !r_prev[i] && (r_edge[i] != '1)) r_edge[i] <= r_edge[i] + 1'b1;
        end
    end
`endif

    // DONE is written last so its latch/sticky values win over a same-cycle clear or STATUS read
    always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            r_done <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_latch[i] <= '0;
`ifdef MULTI_PROBE_EDGE_EN
            for (int i = 0; i < NUM_CH; i++) r_edge_latch[i] <= '0;
`endif
        end else begin
            if (w_clear || w_status_rd) r_done <= 1'b0;
            if (w_clear) begin
                for (int i = 0; i < NUM_CH; i++) r_latch[i] <= '0;
`ifdef MULTI_PROBE_EDGE_EN
                for (int i = 0; i < NUM_CH; i++) r_edge_latch[i] <= '0;
`endif
            end
            if (r_state == S_DONE) begin
                r_done <= 1'b1;
                for (int i = 0; i < NUM_CH; i++) r_latch[i] <= r_cnt[i];
`ifdef MULTI_PROBE_EDGE_EN
                for (int i = 0; i < NUM_CH; i++) r_edge_latch[i] <= r_edge[i];
`endif
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (NATIVE_ADDR == ADDR_CTRL)
            w_rdata[1] = r_cont;
        else if (NATIVE_ADDR == ADDR_STATUS)
            w_rdata[1:0] = {r_done, w_busy};
        else if (NATIVE_ADDR == ADDR_AVER)
            w_rdata = NATIVE_DATA_WIDTH'(r_aver);
        for (int i = 0; i < NUM_CH; i++) begin
            if (NATIVE_ADDR == NATIVE_ADDR_WDITH'(3 + i))
                w_rdata = NATIVE_DATA_WIDTH'(r_latch[i]);
`ifdef MULTI_PROBE_EDGE_EN
            if (NATIVE_ADDR == NATIVE_ADDR_WDITH'(3 + NUM_CH + i))
                w_rdata = NATIVE_DATA_WIDTH'(r_edge_latch[i]);
`endif
        end
    end

    always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            r_cont  <= 1'b0;
            r_aver  <= AW'(AVER_DEFAULT);
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= NATIVE_EN;
            if (NATIVE_EN) r_rdata <= NATIVE_WR ? '0 : w_rdata;
            if (w_wr && (NATIVE_ADDR == ADDR_CTRL)) r_cont <= NATIVE_DATA_IN[1];
            if (w_aver_wr) r_aver <= AW'(NATIVE_DATA_IN);
        end
    end

endmodule

// File: tb/tb_multi_probe_detector.sv
// Bench for multi_probe_detector: a 16-bit and a 4-bit counter instance share all stimulus,
// per-window counts are predicted from the list of probe values presented at each trigger.
module tb_multi_probe_detector;
    localparam int NCH   = 4;
    localparam int SAT_A = 65535;
    localparam int SAT_B = 15;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0, wr = 1'b0;
    logic [3:0]     addr = '0;
    logic [31:0]    wdata = '0;
    logic [NCH-1:0] probe = '0;
    logic [31:0]    rdata_a, rdata_b;
    logic           ready_a, ready_b, trig_a, trig_b, irq_a, irq_b;

    int checks = 0, passed = 0;
    int cyc = 0;
    int trig_cyc[$];
    int irq_cyc[$];
    logic [NCH-1:0] hist[$];
    int pmode = 0;
    logic [NCH-1:0] pfixed = '0;
    int diverge = 0;

    multi_probe_detector u_dut_a (
        .S_AXI_aclk(clk), .S_AXI_aresetn(rst_n), .NATIVE_EN(en), .NATIVE_WR(wr),
        .NATIVE_ADDR(addr), .NATIVE_DATA_IN(wdata), .NATIVE_DATA_OUT(rdata_a),
        .NATIVE_READY(ready_a), .probe_signal_in(probe), .trigger_data_out(trig_a), .done_irq(irq_a));

    multi_probe_detector #(.CNT_WIDTH(4)) u_dut_b (
        .S_AXI_aclk(clk), .S_AXI_aresetn(rst_n), .NATIVE_EN(en), .NATIVE_WR(wr),
        .NATIVE_ADDR(addr), .NATIVE_DATA_IN(wdata), .NATIVE_DATA_OUT(rdata_b),
        .NATIVE_READY(ready_b), .probe_signal_in(probe), .trigger_data_out(trig_b), .done_irq(irq_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // New probe value is applied while the trigger is high; it reaches the sampler two edges later.
    initial begin
        forever begin
            @(negedge clk);
            if (trig_a) begin
                case (pmode)
                    0: probe = pfixed;
                    1: probe = NCH'($urandom);
                    default: probe = probe ^ 4'b0010;
                endcase
                hist.push_back(probe);
                trig_cyc.push_back(cyc);
            end
            if (irq_a) irq_cyc.push_back(cyc);
            if (trig_a !== trig_b || irq_a !== irq_b) diverge++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [31:0] da, output logic [31:0] db);
        @(negedge clk);
        en = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        en = 1'b0;
        da = rdata_a; db = rdata_b;
    endtask

    task automatic wait_irq(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (irq_cyc.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic clear_log();
        trig_cyc.delete(); irq_cyc.delete(); hist.delete(); diverge = 0;
    endtask

    task automatic run_window(input int aver, output bit ok);
        wr_reg(4'd2, 32'(aver));
        clear_log();
        wr_reg(4'd0, 32'd1);
        wait_irq(1, ((aver < 1) ? 1 : aver) * 5 + 20, ok);
        repeat (8) @(posedge clk);
    endtask

    function automatic int model_hits(input int ch, input int maxv);
        int s = 0;
        foreach (hist[j]) if (hist[j][ch]) s++;
        return (s > maxv) ? maxv : s;
    endfunction

    function automatic int model_edges(input int ch, input int maxv);
        int s = 0;
        logic p = 1'b0;
        foreach (hist[j]) begin
            if (hist[j][ch] && !p) s++;
            p = hist[j][ch];
        end
        return (s > maxv) ? maxv : s;
    endfunction

    task automatic test_reset();
        logic [31:0] da, db;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({trig_a, trig_b, irq_a, irq_b, ready_a, ready_b} !== 6'b0)
            $display("FAIL reset_outputs: got %b expected 000000", {trig_a, trig_b, irq_a, irq_b, ready_a, ready_b});
        else passed++;
        rst_n = 1'b1;
        rd_reg(4'd2, da, db);
        checks++;
        if (da !== 32'd10000 || db !== 32'd10000) $display("FAIL reset_aver: got %0d/%0d expected 10000", da, db);
        else passed++;
        rd_reg(4'd1, da, db);
        checks++;
        if (da !== 32'd0 || db !== 32'd0) $display("FAIL reset_status: got %0d/%0d expected 0", da, db);
        else passed++;
        for (int i = 0; i < 2 * NCH; i++) begin
            rd_reg(4'(3 + i), da, db);
            checks++;
            if (da !== 32'd0 || db !== 32'd0) $display("FAIL reset_count addr%0d: got %0d/%0d expected 0", 3 + i, da, db);
            else passed++;
        end
    endtask

    task automatic test_handshake();
        logic [31:0] da, db;
        @(negedge clk);
        en = 1'b1; wr = 1'b0; addr = 4'd2;
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1 || rdata_a !== 32'd10000)
            $display("FAIL ready_pulse: got ready %b%b data %0d expected 11 and 10000", ready_a, ready_b, rdata_a);
        else passed++;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) $display("FAIL ready_width: got %b%b expected 00", ready_a, ready_b);
        else passed++;
        wr_reg(4'd13, 32'hFFFF_FFFF);
        for (int a = 3 + 2 * NCH; a < 16; a++) begin
            rd_reg(4'(a), da, db);
            checks++;
            if (da !== 32'd0 || db !== 32'd0) $display("FAIL unmapped addr%0d: got %0d/%0d expected 0", a, da, db);
            else passed++;
        end
        wr_reg(4'd0, 32'd2);
        rd_reg(4'd0, da, db);
        checks++;
        if (da !== 32'd2 || db !== 32'd2) $display("FAIL ctrl_readback: got %0d/%0d expected 2", da, db);
        else passed++;
        rd_reg(4'd1, da, db);
        checks++;
        if (da !== 32'd0) $display("FAIL ctrl_no_start: got status %0d expected 0", da);
        else passed++;
        wr_reg(4'd0, 32'd0);
    endtask

    task automatic test_basic();
        logic [31:0] da, db;
        bit ok;
        int bad;
        int exp_cnt [NCH] = '{8, 0, 8, 0};
        pmode = 0; pfixed = 4'b0101;
        run_window(8, ok);
        checks++;
        if (!ok) $display("FAIL basic_done_timeout: got no done_irq expected one");
        else passed++;
        checks++;
        if (trig_cyc.size() != 8 || irq_cyc.size() != 1)
            $display("FAIL basic_pulses: got %0d triggers %0d irqs expected 8 and 1", trig_cyc.size(), irq_cyc.size());
        else passed++;
        bad = 0;
        for (int k = 1; k < trig_cyc.size(); k++) if (trig_cyc[k] - trig_cyc[k-1] != 5) bad++;
        checks++;
        if (bad != 0) $display("FAIL basic_spacing: got %0d gaps not 5 expected 0", bad);
        else passed++;
        if (trig_cyc.size() > 0 && irq_cyc.size() > 0) begin
            checks++;
            if (irq_cyc[0] - trig_cyc[trig_cyc.size()-1] != 5)
                $display("FAIL basic_irq_latency: got %0d expected 5", irq_cyc[0] - trig_cyc[trig_cyc.size()-1]);
            else passed++;
        end
        for (int i = 0; i < NCH; i++) begin
            rd_reg(4'(3 + i), da, db);
            checks++;
            if (da !== 32'(exp_cnt[i]) || db !== 32'(exp_cnt[i]))
                $display("FAIL basic_count ch%0d: got %0d/%0d expected %0d", i, da, db, exp_cnt[i]);
            else passed++;
        end
        rd_reg(4'd1, da, db);
        checks++;
        if (da !== 32'd2 || db !== 32'd2) $display("FAIL basic_status_done: got %0d/%0d expected 2", da, db);
        else passed++;
        rd_reg(4'd1, da, db);
        checks++;
        if (da !== 32'd0 || db !== 32'd0) $display("FAIL basic_status_cleared: got %0d/%0d expected 0", da, db);
        else passed++;
        checks++;
        if (diverge != 0) $display("FAIL basic_instances_agree: got %0d differing cycles expected 0", diverge);
        else passed++;
    endtask

    task automatic test_saturation();
        logic [31:0] da, db;
        bit ok;
        pmode = 0; pfixed = 4'b0001;
        run_window(20, ok);
        rd_reg(4'd3, da, db);
        checks++;
        if (!ok || da !== 32'd20 || db !== 32'd15)
            $display("FAIL saturation_count0: got %0d/%0d expected 20/15", da, db);
        else passed++;
        rd_reg(4'd4, da, db);
        checks++;
        if (da !== 32'd0 || db !== 32'd0) $display("FAIL saturation_count1: got %0d/%0d expected 0", da, db);
        else passed++;
    endtask

    task automatic test_edges();
        logic [31:0] da, db;
        bit ok;
        int e;
        probe = '0; pmode = 2;
        run_window(8, ok);
        rd_reg(4'd4, da, db);
        checks++;
        if (!ok || da !== 32'd4 || db !== 32'd4) $display("FAIL toggle_hits ch1: got %0d/%0d expected 4", da, db);
        else passed++;
`ifdef MULTI_PROBE_EDGE_EN
        e = 4;
`else
        e = 0;
`endif
        rd_reg(4'(3 + NCH + 1), da, db);
        checks++;
        if (da !== 32'(e) || db !== 32'(e)) $display("FAIL toggle_edges ch1: got %0d/%0d expected %0d", da, db, e);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] da, db;
        bit ok;
        int aver, ea, eb;
        pmode = 1;
        for (int w = 0; w < 6; w++) begin
            aver = (w == 0) ? 0 : int'($urandom_range(1, 24));
            run_window(aver, ok);
            checks++;
            if (!ok || trig_cyc.size() != ((aver < 1) ? 1 : aver))
                $display("FAIL rand_samples w%0d: got %0d expected %0d", w, trig_cyc.size(), (aver < 1) ? 1 : aver);
            else passed++;
            for (int i = 0; i < NCH; i++) begin
                rd_reg(4'(3 + i), da, db);
                ea = model_hits(i, SAT_A); eb = model_hits(i, SAT_B);
                checks++;
                if (da !== 32'(ea) || db !== 32'(eb))
                    $display("FAIL rand_hits w%0d ch%0d: got %0d/%0d expected %0d/%0d", w, i, da, db, ea, eb);
                else passed++;
`ifdef MULTI_PROBE_EDGE_EN
                ea = model_edges(i, SAT_A); eb = model_edges(i, SAT_B);
`else
                ea = 0; eb = 0;
`endif
                rd_reg(4'(3 + NCH + i), da, db);
                checks++;
                if (da !== 32'(ea) || db !== 32'(eb))
                    $display("FAIL rand_edges w%0d ch%0d: got %0d/%0d expected %0d/%0d", w, i, da, db, ea, eb);
                else passed++;
            end
            rd_reg(4'd1, da, db);
            checks++;
            if (da !== 32'd2 || db !== 32'd2) $display("FAIL rand_status w%0d: got %0d/%0d expected 2", w, da, db);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        pmode = 0; pfixed = 4'b0011;
        wr_reg(4'd2, 32'd4);
        clear_log();
        wr_reg(4'd0, 32'd1);
        repeat (5) @(posedge clk);
        wr_reg(4'd0, 32'd1);
        wait_irq(1, 60, ok);
        wr_reg(4'd0, 32'd1);
        wait_irq(2, 60, ok);
        repeat (30) @(posedge clk);
        checks++;
        if (!ok || trig_cyc.size() != 8 || irq_cyc.size() != 2)
            $display("FAIL back_to_back: got %0d triggers %0d irqs expected 8 and 2", trig_cyc.size(), irq_cyc.size());
        else passed++;
    endtask

    task automatic test_continuous();
        logic [31:0] da, db;
        bit ok;
        pmode = 0; pfixed = 4'b1111;
        wr_reg(4'd2, 32'd3);
        clear_log();
        wr_reg(4'd0, 32'd3);
        wait_irq(3, 100, ok);
        checks++;
        if (!ok || irq_cyc[1] - irq_cyc[0] != 17 || irq_cyc[2] - irq_cyc[1] != 17)
            $display("FAIL cont_period: got %0d irqs expected 3 spaced 17", irq_cyc.size());
        else passed++;
        wr_reg(4'd2, 32'd100);
        wr_reg(4'd0, 32'd0);
        wait_irq(4, 60, ok);
        repeat (40) @(posedge clk);
        checks++;
        if (!ok || irq_cyc.size() != 4 || irq_cyc[3] - irq_cyc[2] != 17)
            $display("FAIL cont_stop: got %0d irqs expected 4 with last gap 17", irq_cyc.size());
        else passed++;
        rd_reg(4'd1, da, db);
        checks++;
        if (da !== 32'd2 || db !== 32'd2) $display("FAIL cont_idle_status: got %0d/%0d expected 2", da, db);
        else passed++;
        rd_reg(4'd2, da, db);
        checks++;
        if (da !== 32'd3 || db !== 32'd3) $display("FAIL cont_aver_locked: got %0d/%0d expected 3", da, db);
        else passed++;
    endtask

    task automatic test_clear();
        logic [31:0] da, db;
        wr_reg(4'd2, 32'd5);
        rd_reg(4'd3, da, db);
        checks++;
        if (da !== 32'd3 || db !== 32'd3) $display("FAIL clear_pre_count: got %0d/%0d expected 3", da, db);
        else passed++;
        wr_reg(4'd0, 32'd4);
        for (int i = 0; i < NCH; i++) begin
            rd_reg(4'(3 + i), da, db);
            checks++;
            if (da !== 32'd0 || db !== 32'd0) $display("FAIL clear_count ch%0d: got %0d/%0d expected 0", i, da, db);
            else passed++;
        end
        rd_reg(4'd1, da, db);
        checks++;
        if (da !== 32'd0 || db !== 32'd0) $display("FAIL clear_status: got %0d/%0d expected 0", da, db);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] da, db;
        bit ok;
        int seen;
        pmode = 0; pfixed = 4'b1111;
        run_window(4, ok);
        rd_reg(4'd3, da, db);
        checks++;
        if (!ok || da !== 32'd4) $display("FAIL rstmid_pre_count: got %0d expected 4", da);
        else passed++;
        wr_reg(4'd2, 32'd8);
        clear_log();
        wr_reg(4'd0, 32'd1);
        seen = 0;
        for (int k = 0; k < 100 && seen < 2; k++) begin
            @(negedge clk);
            if (trig_a) seen++;
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (seen != 2 || trig_a !== 1'b0 || trig_b !== 1'b0)
            $display("FAIL rstmid_trigger: got seen %0d trig %b%b expected 2 and 00", seen, trig_a, trig_b);
        else passed++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        checks++;
        if (irq_cyc.size() != 0 || trig_cyc.size() != 2)
            $display("FAIL rstmid_no_irq: got %0d irqs %0d triggers expected 0 and 2", irq_cyc.size(), trig_cyc.size());
        else passed++;
        for (int i = 0; i < NCH; i++) begin
            rd_reg(4'(3 + i), da, db);
            checks++;
            if (da !== 32'd0 || db !== 32'd0) $display("FAIL rstmid_count ch%0d: got %0d/%0d expected 0", i, da, db);
            else passed++;
        end
        rd_reg(4'd2, da, db);
        checks++;
        if (da !== 32'd10000 || db !== 32'd10000) $display("FAIL rstmid_aver: got %0d/%0d expected 10000", da, db);
        else passed++;
        rd_reg(4'd1, da, db);
        checks++;
        if (da !== 32'd0 || db !== 32'd0) $display("FAIL rstmid_status: got %0d/%0d expected 0", da, db);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_basic();
        test_saturation();
        test_edges();
        test_random();
        test_back_to_back();
        test_continuous();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
